// File: rtl/score_controller_if.sv
// Register-file port of the score controller: request/write side driven by the
// controller (master), read data returned by the register file (slave).
interface score_controller_if;
    logic       sc_en;
    logic       sc_readwrite;
    logic       sc_type;
    logic [7:0] sc_wr_data;
    logic       sc_clear;
    logic [7:0] rd_data;

    modport master (
        output sc_en,
        output sc_readwrite,
        output sc_type,
        output sc_wr_data,
        output sc_clear,
        input  rd_data
    );

    modport slave (
        input  sc_en,
        input  sc_readwrite,
        input  sc_type,
        input  sc_wr_data,
        input  sc_clear,
        output rd_data
    );
endinterface

// File: rtl/score_controller.sv
// Turns gameplay event pulses into read-modify-write transactions on the player
// score/lives register file. Define SCORE_EXTRA_LIFE_EN for the one-shot extra life at 100 points.
module score_controller #(
    parameter int PELLET_PTS  = 1,
    parameter int POWER_PTS   = 5,
    parameter int GHOST_PTS   = 20,
    parameter int START_LIVES = 3
) (
    input  logic               clock_50,
    input  logic               reset_n,
    input  logic               new_game,
    input  logic               ev_pellet,
    input  logic               ev_power,
    input  logic               ev_ghost,
    input  logic               ev_death,
    score_controller_if.master rf,
    output logic               busy,
    output logic               game_over
);
    typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;
    typedef enum logic [2:0] {ITEM_PELLET, ITEM_POWER, ITEM_GHOST, ITEM_DEATH, ITEM_EXTRA} item_t;

    localparam logic [8:0] PELLET_P9 = 9'(PELLET_PTS);
    localparam logic [8:0] POWER_P9  = 9'(POWER_PTS);
    localparam logic [8:0] GHOST_P9  = 9'(GHOST_PTS);
    localparam logic [1:0] LIVES_CAP = 2'(START_LIVES);

    state_t     state_reg, state_next;
    item_t      item_reg, item_next;
    logic       take;
    logic [3:0] pellet_cnt_reg, pellet_sat;
    logic [1:0] power_cnt_reg, power_sat;
    logic [1:0] ghost_cnt_reg, ghost_sat;
    logic       death_pend_reg;
    logic [7:0] hold_reg;
    logic       game_over_reg;
    logic       clear_reg;
    logic       is_lives_item;
    logic [8:0] points;
    logic [8:0] score_sum;
    logic [1:0] lives_lo;
    logic [7:0] calc_value;
`ifdef SCORE_EXTRA_LIFE_EN
    logic       extra_pend_reg;
    logic       life_used_reg;
    logic       extra_set;
`endif

    assign is_lives_item = (item_reg == ITEM_DEATH) || (item_reg == ITEM_EXTRA);

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            item_reg  <= ITEM_PELLET;
        end else begin
            state_reg <= state_next;
            item_reg  <= item_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        item_next       = item_reg;
        take            = 1'b0;
        rf.sc_en        = 1'b0;
        rf.sc_readwrite = 1'b0;
        rf.sc_type      = 1'b0;
        rf.sc_wr_data   = 8'd0;
        case (state_reg)
            IDLE: begin
                if (!game_over_reg) begin
                    take = 1'b1;
                    if (death_pend_reg)              item_next = ITEM_DEATH;
                    else if (ghost_cnt_reg != 2'd0)  item_next = ITEM_GHOST;
                    else if (power_cnt_reg != 2'd0)  item_next = ITEM_POWER;
                    else if (pellet_cnt_reg != 4'd0) item_next = ITEM_PELLET;
`ifdef SCORE_EXTRA_LIFE_EN
                    else if (extra_pend_reg)         item_next = ITEM_EXTRA;
`endif
                    else                             take = 1'b0;
                    if (take) state_next = READ;
                end
            end
            READ: begin
                rf.sc_en   = 1'b1;
                rf.sc_type = is_lives_item;
                state_next = CALC;
            end
            CALC: state_next = WRITE;
            WRITE: begin
                rf.sc_en        = 1'b1;
                rf.sc_readwrite = 1'b1;
                rf.sc_type      = is_lives_item;
                rf.sc_wr_data   = hold_reg;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // new_game aborts whatever is in flight; the held value is never written
        if (new_game) begin
            state_next = IDLE;
            take       = 1'b0;
        end
    end

    always_comb begin
        case (item_reg)
            ITEM_POWER: points = POWER_P9;
            ITEM_GHOST: points = GHOST_P9;
            default:    points = PELLET_P9;
        endcase
        score_sum  = {1'b0, rf.rd_data} + points;
        lives_lo   = rf.rd_data[1:0];
        calc_value = score_sum[8] ? 8'hFF : score_sum[7:0];
        if (item_reg == ITEM_DEATH)
            calc_value = {6'd0, (lives_lo == 2'd0) ? 2'd0 : lives_lo - 2'd1};
        else if (item_reg == ITEM_EXTRA)
            calc_value = {6'd0, (lives_lo >= LIVES_CAP) ? LIVES_CAP : lives_lo + 2'd1};
    end

    assign pellet_sat = (ev_pellet && pellet_cnt_reg != 4'hF) ? pellet_cnt_reg + 4'd1 : pellet_cnt_reg;
    assign power_sat  = (ev_power  && power_cnt_reg  != 2'h3) ? power_cnt_reg  + 2'd1 : power_cnt_reg;
    assign ghost_sat  = (ev_ghost  && ghost_cnt_reg  != 2'h3) ? ghost_cnt_reg  + 2'd1 : ghost_cnt_reg;

`ifdef SCORE_EXTRA_LIFE_EN
    assign extra_set = (state_reg == CALC) && !is_lives_item && !life_used_reg
                       && (rf.rd_data < 8'd100) && (calc_value >= 8'd100);
`endif

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            pellet_cnt_reg <= 4'd0;
            power_cnt_reg  <= 2'd0;
            ghost_cnt_reg  <= 2'd0;
            death_pend_reg <= 1'b0;
            hold_reg       <= 8'd0;
            game_over_reg  <= 1'b0;
            clear_reg      <= 1'b0;
`ifdef SCORE_EXTRA_LIFE_EN
            extra_pend_reg <= 1'b0;
            life_used_reg  <= 1'b0;
`endif
        end else if (new_game) begin
            pellet_cnt_reg <= 4'd0;
            power_cnt_reg  <= 2'd0;
            ghost_cnt_reg  <= 2'd0;
            death_pend_reg <= 1'b0;
            hold_reg       <= 8'd0;
            game_over_reg  <= 1'b0;
            clear_reg      <= 1'b1;
`ifdef SCORE_EXTRA_LIFE_EN
            extra_pend_reg <= 1'b0;
            life_used_reg  <= 1'b0;
`endif
        end else begin
            clear_reg <= 1'b0;
            if (game_over_reg) begin
                pellet_cnt_reg <= 4'd0;
                power_cnt_reg  <= 2'd0;
                ghost_cnt_reg  <= 2'd0;
                death_pend_reg <= 1'b0;
`ifdef SCORE_EXTRA_LIFE_EN
                extra_pend_reg <= 1'b0;
`endif
            end else begin
                // capture (saturating) first, then consume the unit selected this cycle
                pellet_cnt_reg <= pellet_sat - {3'd0, take && (item_next == ITEM_PELLET)};
                power_cnt_reg  <= power_sat  - {1'b0, take && (item_next == ITEM_POWER)};
                ghost_cnt_reg  <= ghost_sat  - {1'b0, take && (item_next == ITEM_GHOST)};
                death_pend_reg <= (death_pend_reg | ev_death) & ~(take && (item_next == ITEM_DEATH));
`ifdef SCORE_EXTRA_LIFE_EN
                extra_pend_reg <= (extra_pend_reg & ~(take && (item_next == ITEM_EXTRA))) | extra_set;
`endif
            end
            if (state_reg == CALC) begin
                hold_reg <= calc_value;
                if (item_reg == ITEM_DEATH && calc_value == 8'd0)
                    game_over_reg <= 1'b1;
            end
`ifdef SCORE_EXTRA_LIFE_EN
            life_used_reg <= life_used_reg | extra_set;
`endif
        end
    end

    assign rf.sc_clear = clear_reg;
    assign busy        = (state_reg != IDLE);
    assign game_over   = game_over_reg;
endmodule

// File: tb/tb_score_controller.sv
// Self-checking bench for score_controller: directed scenarios plus random event
// traffic, compared cycle by cycle against a behavioural transaction model.
module tb_score_controller;
    localparam int START_LIVES = 3;

    logic clock_50 = 1'b0;
    logic reset_n  = 1'b0;
    logic new_game = 1'b0;
    logic ev_pellet = 1'b0, ev_power = 1'b0, ev_ghost = 1'b0, ev_death = 1'b0;
    logic busy, game_over;

    score_controller_if sc_bus();

    score_controller #(
        .PELLET_PTS(1), .POWER_PTS(5), .GHOST_PTS(20), .START_LIVES(START_LIVES)
    ) dut (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .new_game (new_game),
        .ev_pellet(ev_pellet),
        .ev_power (ev_power),
        .ev_ghost (ev_ghost),
        .ev_death (ev_death),
        .rf       (sc_bus),
        .busy     (busy),
        .game_over(game_over)
    );

    always #5 clock_50 = ~clock_50;

    int checks = 0;
    int failures = 0;

    // behavioural model: item 0 pellet, 1 power, 2 ghost, 3 death, 4 extra life
    int m_phase, m_item, m_wval, m_score, m_lives;
    int pend[5];
    bit m_go, m_clr, m_used;

    // register-file environment and observation logs
    logic [7:0] mem[2];
    bit         prev_read;
    logic [8:0] wlog[$];
    int         n_en, n_busy, n_reads, last_rtype;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pts_of(input int item);
        case (item)
            1: return 5;
            2: return 20;
            default: return 1;
        endcase
    endfunction

    function automatic int cap_of(input int item);
        case (item)
            0: return 15;
            1: return 3;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [8:0] wr_at(input int i);
        if (i < wlog.size()) return wlog[i];
        return 'x;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_item = 0; m_wval = 0; m_go = 0; m_clr = 0; m_used = 0;
        for (int i = 0; i < 5; i++) pend[i] = 0;
    endtask

    task automatic model_step(input logic [3:0] ev, input logic ng);
        int  take_i;
        bit  old_go;
        bit  set_extra;
        int  l;
        take_i = -1; set_extra = 0;
        if (ng) begin
            model_reset();
            m_clr = 1; m_score = 0; m_lives = START_LIVES;
            return;
        end
        m_clr  = 0;
        old_go = m_go;
        case (m_phase)
            0: if (!m_go) begin
                if      (pend[3] > 0) take_i = 3;
                else if (pend[2] > 0) take_i = 2;
                else if (pend[1] > 0) take_i = 1;
                else if (pend[0] > 0) take_i = 0;
                else if (pend[4] > 0) take_i = 4;
                if (take_i >= 0) begin m_item = take_i; m_phase = 1; end
            end
            1: m_phase = 2;
            2: begin
                l = m_lives % 4;
                if (m_item == 3) begin
                    m_wval = (l == 0) ? 0 : l - 1;
                    if (m_wval == 0) m_go = 1;
                end else if (m_item == 4) begin
                    m_wval = (l >= START_LIVES) ? START_LIVES : l + 1;
                end else begin
                    m_wval = m_score + pts_of(m_item);
                    if (m_wval > 255) m_wval = 255;
`ifdef SCORE_EXTRA_LIFE_EN
                    if (m_score < 100 && m_wval >= 100 && !m_used) begin
                        set_extra = 1; m_used = 1;
                    end
`endif
                end
                m_phase = 3;
            end
            default: begin
                if (m_item >= 3) m_lives = m_wval; else m_score = m_wval;
                m_phase = 0;
            end
        endcase
        if (old_go) begin
            for (int i = 0; i < 5; i++) pend[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pend[i] = pend[i] + int'(ev[i]);
                if (pend[i] > cap_of(i)) pend[i] = cap_of(i);
                if (take_i == i) pend[i]--;
            end
            if (take_i == 4) pend[4]--;
            if (set_extra) pend[4] = 1;
        end
    endtask

    task automatic check_outputs();
        bit act;
        act = (m_phase == 1) || (m_phase == 3);
        check("sc_en",        sc_bus.sc_en,        act);
        check("sc_readwrite", sc_bus.sc_readwrite, m_phase == 3);
        check("sc_type",      sc_bus.sc_type,      act && m_item >= 3);
        check("sc_wr_data",   sc_bus.sc_wr_data,   (m_phase == 3) ? m_wval : 0);
        check("sc_clear",     sc_bus.sc_clear,     m_clr);
        check("busy",         busy,                m_phase != 0);
        check("game_over",    game_over,           m_go);
    endtask

    task automatic env_update();
        if (busy) n_busy++;
        if (sc_bus.sc_en) n_en++;
        if (sc_bus.sc_en && !sc_bus.sc_readwrite) begin
            sc_bus.rd_data = mem[sc_bus.sc_type];
            n_reads++;
            last_rtype = int'(sc_bus.sc_type);
            prev_read  = 1;
        end else if (prev_read) begin
            prev_read = 0;
        end else begin
            sc_bus.rd_data = 8'($urandom);
        end
        if (sc_bus.sc_en && sc_bus.sc_readwrite) begin
            mem[sc_bus.sc_type] = sc_bus.sc_wr_data;
            wlog.push_back({sc_bus.sc_type, sc_bus.sc_wr_data});
        end
        if (sc_bus.sc_clear) begin
            mem[0] = 8'd0;
            mem[1] = 8'(START_LIVES);
        end
    endtask

    task automatic cycle(input logic [3:0] ev, input logic ng);
        {ev_death, ev_ghost, ev_power, ev_pellet} = ev;
        new_game = ng;
        model_step(ev, ng);
        @(negedge clock_50);
        {ev_death, ev_ghost, ev_power, ev_pellet} = 4'd0;
        new_game = 1'b0;
        check_outputs();
        env_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'd0, 1'b0);
    endtask

    task automatic preload(input int s, input int l);
        mem[0] = 8'(s); mem[1] = 8'(l);
        m_score = s; m_lives = l;
    endtask

    task automatic clear_logs();
        wlog.delete();
        n_en = 0; n_busy = 0; n_reads = 0; last_rtype = -1;
    endtask

    initial begin
        logic [3:0] ev;
        logic       ng;
        sc_bus.rd_data = 8'd0;
        prev_read = 0;
        model_reset();
        preload(0, START_LIVES);
        clear_logs();

        // reset state
        repeat (3) @(negedge clock_50);
        check_outputs();
        reset_n = 1'b1;

        // single pellet, score 7 -> 8
        preload(7, 3); clear_logs();
        cycle(4'b0001, 1'b0); idle(6);
        check("t1_writes", wlog.size(), 1);
        check("t1_wdata",  wr_at(0), 9'h008);
        check("t1_busy",   n_busy, 3);
        check("t1_reads",  n_reads, 1);
        check("t1_rtype",  last_rtype, 0);

        // ghost + pellet together at 250 saturate
        preload(250, 3); clear_logs();
        cycle(4'b0101, 1'b0); idle(10);
        check("t2_writes", wlog.size(), 2);
        check("t2_first",  wr_at(0), 9'h0FF);
        check("t2_second", wr_at(1), 9'h0FF);

        // three deaths -> game over; later events ignored
        preload(40, 3); clear_logs();
        for (int k = 0; k < 3; k++) begin cycle(4'b1000, 1'b0); idle(5); end
        check("t3_writes", wlog.size(), 3);
        check("t3_w0", wr_at(0), 9'h102);
        check("t3_w1", wr_at(1), 9'h101);
        check("t3_w2", wr_at(2), 9'h100);
        check("t3_game_over", game_over, 1'b1);
        clear_logs();
        cycle(4'b0001, 1'b0); idle(8);
        check("t3_no_en", n_en, 0);
        cycle(4'b0000, 1'b1);
        check("t3_clear", sc_bus.sc_clear, 1'b1);
        idle(2);

        // 20 pellets queued behind higher-priority work: counter saturates at 15
        preload(0, 3); clear_logs();
        cycle(4'b1111, 1'b0);
        cycle(4'b0111, 1'b0);
        cycle(4'b0111, 1'b0);
        for (int k = 0; k < 17; k++) cycle(4'b0001, 1'b0);
        idle(150);
        check("t4_writes", wlog.size(), 22);
        check("t4_score",  mem[0], 8'd90);
        check("t4_lives",  mem[1], 8'd2);

        // new_game during CALC aborts the write
        preload(10, 3); clear_logs();
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b1);
        check("t5_busy",  busy, 1'b0);
        check("t5_clear", sc_bus.sc_clear, 1'b1);
        check("t5_go",    game_over, 1'b0);
        idle(1);
        check("t5_clear_one", sc_bus.sc_clear, 1'b0);
        idle(6);
        check("t5_writes", wlog.size(), 0);

`ifdef SCORE_EXTRA_LIFE_EN
        // extra life when crossing 100, only once per game
        preload(98, 2); clear_logs();
        cycle(4'b0010, 1'b0); idle(12);
        check("t6_writes", wlog.size(), 2);
        check("t6_score",  wr_at(0), 9'h067);
        check("t6_life",   wr_at(1), 9'h103);
        preload(95, 2);
        cycle(4'b0010, 1'b0); idle(12);
        check("t6_once",   wlog.size(), 3);
        check("t6_score2", wr_at(2), 9'h064);
`endif

        // random traffic
        for (int i = 0; i < 800; i++) begin
            ev[0] = ($urandom_range(0, 3) == 0);
            ev[1] = ($urandom_range(0, 9) == 0);
            ev[2] = ($urandom_range(0, 9) == 0);
            ev[3] = ($urandom_range(0, 29) == 0);
            ng    = m_go ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
            cycle(ev, ng);
        end
        cycle(4'b0000, 1'b1);
        idle(2);

        // reset asserted mid-transaction
        clear_logs();
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_en",   sc_bus.sc_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wd",   sc_bus.sc_wr_data, 8'd0);
        @(negedge clock_50);
        prev_read = 0;
        check_outputs();
        reset_n = 1'b1;
        idle(6);
        check("rst_writes", wlog.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
